// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master command port among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to enable the WAIT-state watchdog bounded by TIMEOUT_CYCLES.
module i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ-1:0]     rw_i,
  input  logic [7*NUM_REQ-1:0]   addr_i,
  input  logic [8*NUM_REQ-1:0]   data_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic                   nack_o,
  output logic                   timeout_o,
  output logic [7:0]             data_o,
  output logic                   m_start_o,
  output logic                   m_rw_o,
  output logic [6:0]             m_addr_o,
  output logic [7:0]             m_data_o,
  input  logic                   m_busy_i,
  input  logic                   m_done_i,
  input  logic                   m_ack_i,
  input  logic [7:0]             m_data_i
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q;
  logic [IDXW-1:0]     last_q;
  logic [IDXW-1:0]     win_q;
  logic [IDXW-1:0]     pick_d;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                nack_q;
  logic [7:0]          data_q;
  logic                m_start_q;
  logic                m_rw_q;
  logic [6:0]          m_addr_q;
  logic [7:0]          m_data_q;
  int                  idx;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNTW-1:0]     cnt_q;
  logic                timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Scan from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    pick_d = '0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (req_i[idx]) pick_d = IDXW'(idx);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= IDXW'(NUM_REQ - 1);
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      nack_q    <= 1'b0;
      data_q    <= '0;
      m_start_q <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      m_start_q <= 1'b0;
      done_q    <= '0;
      nack_q    <= 1'b0;
      data_q    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            win_q    <= pick_d;
            gnt_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_d;
            m_rw_q   <= rw_i[pick_d];
            m_addr_q <= addr_i[7*int'(pick_d) +: 7];
            m_data_q <= data_i[8*int'(pick_d) +: 8];
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_busy_i) begin
            m_start_q <= 1'b1;
            state_q   <= WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        WAIT: begin
          if (m_done_i) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            nack_q  <= ~m_ack_i;
            data_q  <= m_rw_q ? m_data_i : 8'h00;
            state_q <= RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (cnt_q == CNTW'(TIMEOUT_CYCLES)) begin
            done_q    <= gnt_q;
            gnt_q     <= '0;
            nack_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          last_q  <= win_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign nack_o    = nack_q;
  assign data_o    = data_q;
  assign m_start_o = m_start_q;
  assign m_rw_o    = m_rw_q;
  assign m_addr_o  = m_addr_q;
  assign m_data_o  = m_data_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: commands and responses are queued as stimulus is driven
// and compared when the arbiter emits m_start_o or done_o.
module tb_i2c_arbiter;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct packed {
    logic [3:0] done;
    logic       nack;
    logic [7:0] data;
    logic       timeout;
  } resp_t;

  logic        clk;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [3:0]  rw_i;
  logic [27:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic        nack_o;
  logic        timeout_o;
  logic [7:0]  data_o;
  logic        m_start_o;
  logic        m_rw_o;
  logic [6:0]  m_addr_o;
  logic [7:0]  m_data_o;
  logic        m_busy_i;
  logic        m_done_i;
  logic        m_ack_i;
  logic [7:0]  m_data_i;

  cmd_t  cmdTab [4];
  cmd_t  cmdQ [$];
  resp_t respQ [$];
  int    checks = 0;
  int    errors = 0;

  i2c_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .rw_i(rw_i), .addr_i(addr_i), .data_i(data_i),
    .gnt_o(gnt_o), .done_o(done_o), .nack_o(nack_o), .timeout_o(timeout_o), .data_o(data_o),
    .m_start_o(m_start_o), .m_rw_o(m_rw_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
    .m_busy_i(m_busy_i), .m_done_i(m_done_i), .m_ack_i(m_ack_i), .m_data_i(m_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int n, input logic rw, input logic [6:0] addr, input logic [7:0] data);
    cmdTab[n]          = '{rw: rw, addr: addr, data: data};
    rw_i[n]            = rw;
    addr_i[7*n +: 7]   = addr;
    data_i[8*n +: 8]   = data;
  endtask

  task automatic expectCmd(input int n);
    cmdQ.push_back(cmdTab[n]);
  endtask

  // Master model: answers after 'delay' cycles and queues the response the requester must see.
  task automatic respond(input logic ack, input logic [7:0] rdata, input int delay, input int n);
    respQ.push_back('{done: 4'(1 << n), nack: ~ack, data: (cmdTab[n].rw ? rdata : 8'h00), timeout: 1'b0});
    repeat (delay) @(posedge clk);
    #1 m_done_i = 1'b1; m_ack_i = ack; m_data_i = rdata;
    @(posedge clk);
    #1 m_done_i = 1'b0;
  endtask

  task automatic waitStart(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_start_o && n < 200);
    checkOutput(tag, 32'(m_start_o), 32'd1);
  endtask

  task automatic waitDone(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_o == 4'b0 && n < 200);
    checkOutput(tag, 32'(|done_o), 32'd1);
  endtask

  // Scoreboard: every start and every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (m_start_o) begin
        if (cmdQ.size() == 0) checkOutput("start_unexpected", 32'(m_start_o), 32'd0);
        else begin
          cmd_t c;
          c = cmdQ.pop_front();
          checkOutput("cmd_rw", 32'(m_rw_o), 32'(c.rw));
          checkOutput("cmd_addr", 32'(m_addr_o), 32'(c.addr));
          checkOutput("cmd_data", 32'(m_data_o), 32'(c.data));
        end
      end
      if (done_o != 4'b0) begin
        if (respQ.size() == 0) checkOutput("done_unexpected", 32'(done_o), 32'd0);
        else begin
          resp_t r;
          r = respQ.pop_front();
          checkOutput("resp_done", 32'(done_o), 32'(r.done));
          checkOutput("resp_nack", 32'(nack_o), 32'(r.nack));
          checkOutput("resp_data", 32'(data_o), 32'(r.data));
          checkOutput("resp_timeout", 32'(timeout_o), 32'(r.timeout));
        end
      end else begin
        checkOutput("idle_status", 32'({nack_o, timeout_o, data_o}), 32'd0);
      end
    end
  end

  initial begin
    int n;
    int early;
    int order [5] = '{0, 1, 2, 3, 0};
    rst_i = 1'b1; req_i = '0; rw_i = '0; addr_i = '0; data_i = '0;
    m_busy_i = 1'b0; m_done_i = 1'b0; m_ack_i = 1'b0; m_data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_gnt", 32'(gnt_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_start", 32'(m_start_o), 32'd0);
    checkOutput("rst_cmd", 32'({m_rw_o, m_addr_o, m_data_o}), 32'd0);

    // Single write from requester 0; read-back byte must be masked on a write.
    applyStimulus(0, 1'b0, 7'h50, 8'hA5);
    expectCmd(0);
    @(posedge clk); #1 req_i = 4'b0001;
    @(posedge clk); @(negedge clk);
    checkOutput("s1_gnt", 32'(gnt_o), 32'h1);
    checkOutput("s1_start_early", 32'(m_start_o), 32'd0);
    waitStart("s1_start", n);
    checkOutput("s1_gnt_to_start", 32'(n), 32'd1);
    respond(1'b1, 8'h33, 3, 0);
    waitDone("s1_done", n);
    checkOutput("s1_done_latency", 32'(n), 32'd1);
    req_i = 4'b0000;

    // Stray master completion while idle must be ignored.
    @(posedge clk); #1 m_done_i = 1'b1; m_ack_i = 1'b1;
    @(posedge clk); #1 m_done_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_no_gnt", 32'(gnt_o), 32'd0);

    // Read with NACK from requester 2, which drops its request mid-transaction.
    applyStimulus(2, 1'b1, 7'h3C, 8'h11);
    expectCmd(2);
    @(posedge clk); #1 req_i = 4'b0100;
    waitStart("s2_start", n);
    req_i = 4'b0000;
    checkOutput("s2_gnt_held", 32'(gnt_o), 32'h4);
    respond(1'b0, 8'h7E, 2, 2);
    waitDone("s2_done", n);

    // Busy master holds ISSUE; a stray done during ISSUE is ignored.
    applyStimulus(1, 1'b0, 7'h21, 8'hC3);
    expectCmd(1);
    @(posedge clk); #1 m_busy_i = 1'b1; req_i = 4'b0010;
    @(posedge clk); @(negedge clk);
    checkOutput("s3_gnt", 32'(gnt_o), 32'h2);
    early = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_start_o) early++;
      m_done_i = (i == 4);
    end
    checkOutput("s3_no_start_busy", 32'(early), 32'd0);
    @(posedge clk); #1 m_busy_i = 1'b0;
    @(negedge clk);
    checkOutput("s3_start_wait", 32'(m_start_o), 32'd0);
    @(negedge clk);
    checkOutput("s3_start_after_busy", 32'(m_start_o), 32'd1);
    respond(1'b1, 8'h55, 2, 1);
    waitDone("s3_done", n);
    req_i = 4'b0000;

    // All four requesting from reset: grants rotate 0,1,2,3,0.
    applyStimulus(0, 1'b0, 7'h10, 8'h01);
    applyStimulus(1, 1'b1, 7'h11, 8'h02);
    applyStimulus(2, 1'b0, 7'h12, 8'h03);
    applyStimulus(3, 1'b1, 7'h13, 8'h04);
    @(posedge clk); #1 rst_i = 1'b1; req_i = 4'b1111;
    @(posedge clk); #1 rst_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expectCmd(order[k]);
      waitStart("s4_start", n);
      respond(k != 2, 8'(8'h40 + k), 1, order[k]);
      waitDone("s4_done", n);
    end
    req_i = 4'b0000;

    // Reset in WAIT abandons requester 0; requester 1 is served next.
    applyStimulus(0, 1'b0, 7'h2A, 8'h99);
    expectCmd(0);
    @(posedge clk); #1 req_i = 4'b0001;
    waitStart("s5_start", n);
    @(posedge clk); #1 rst_i = 1'b1; req_i = 4'b0010;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("s5_rst_gnt", 32'(gnt_o), 32'd0);
    checkOutput("s5_rst_addr", 32'(m_addr_o), 32'd0);
    expectCmd(1);
    waitStart("s5_start2", n);
    respond(1'b1, 8'h66, 1, 1);
    waitDone("s5_done", n);
    req_i = 4'b0000;

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: no master completion, abort 17 cycles after the start pulse.
    applyStimulus(0, 1'b1, 7'h5A, 8'h00);
    expectCmd(0);
    respQ.push_back('{done: 4'b0001, nack: 1'b1, data: 8'h00, timeout: 1'b1});
    m_data_i = 8'hEE;
    @(posedge clk); #1 req_i = 4'b0001;
    waitStart("s6_start", n);
    waitDone("s6_done", n);
    checkOutput("s6_timeout_latency", 32'(n), 32'd17);
    req_i = 4'b0000;
    applyStimulus(3, 1'b0, 7'h33, 8'h44);
    expectCmd(3);
    @(posedge clk); #1 req_i = 4'b1000;
    waitStart("s6_resume_start", n);
    respond(1'b1, 8'h00, 1, 3);
    waitDone("s6_resume_done", n);
    req_i = 4'b0000;
`else
    // Without the watchdog a slow master is simply waited for.
    applyStimulus(0, 1'b1, 7'h5A, 8'h00);
    expectCmd(0);
    @(posedge clk); #1 req_i = 4'b0001;
    waitStart("s6_start", n);
    respond(1'b1, 8'hB4, 40, 0);
    waitDone("s6_done", n);
    req_i = 4'b0000;
`endif

    repeat (3) @(negedge clk);
    checkOutput("cmd_queue_empty", 32'(cmdQ.size()), 32'd0);
    checkOutput("resp_queue_empty", 32'(respQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
